if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage. Produces the PC/instruction pair consumed by the decode stage, i.e. the producing end of the IF→ID pipeline interface.
- Owns the PC register, a single-outstanding req/ack instruction-memory port, a one-entry skid buffer and the IF/ID pipeline register.
- Honours freeze from hazard detection and branch redirect/flush from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'hE1A0_0000, bubble instruction (MOV r0,r0) inserted on flush and reset.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  hazard stall; hold PC and IF/ID register.
- branch_taken  input  1  redirect request from execute; also flushes IF/ID.
- branch_address  input  32  redirect target; word aligned.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction.
- PC  output  32  IF/ID register: fetch address + 4.
- instruction  output  32  IF/ID register: instruction word.
- valid  output  1  IF/ID register holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=0, async):
  - pc_reg=RESET_PC; FSM=FETCH; skid buffer empty.
  - PC=0, instruction=NOP_INSTR, valid=0, imem_req=0.
  - First request is issued the first cycle after reset deasserts.
- imem_addr is always pc_reg. Only one request is outstanding. imem_req stays high from issue until the ack cycle.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). branch_address[1:0] is ignored (forced 00).
- FSM states:
  - FETCH:
    - imem_req=1.
    - On ack with !freeze: IF/ID <= {pc_reg+4, imem_rdata, 1}; pc_reg += 4; stay in FETCH.
    - Back-to-back acks give one instruction per cycle; latency is ack-edge to IF/ID output, 1 cycle.
    - On ack with freeze: data goes to the skid buffer; pc_reg += 4; go to HELD.
  - HELD:
    - imem_req=0; IF/ID holds.
    - When freeze=0: IF/ID <= skid; buffer cleared; go to FETCH (request reissued the next cycle).
  - DISCARD:
    - imem_req=1 at the stale address until ack.
    - Acked data is dropped; go to FETCH at the already-updated pc_reg.
- Freeze with no ack: IF/ID and pc_reg hold. In FETCH the outstanding request stays pending.
- branch_taken overrides freeze in every state:
  - IF/ID <= {0, NOP_INSTR, 0}; pc_reg <= branch_address.
  - FETCH, no ack this cycle → DISCARD; address changes only after that ack.
  - FETCH with ack this cycle → data dropped; stay in FETCH at the target.
  - HELD → skid cleared; FETCH at the target.
  - DISCARD → stay in DISCARD with the new target.
- Target tracking: a second branch while in DISCARD overwrites the pending target. A separate next_pc is kept so imem_addr stays stable for the stale request.
- Simultaneous events: ack+branch+freeze in the same cycle → branch wins; the ack data is discarded.
- Reset mid-request: state is cleared immediately. The memory model must abort on reset. An ack arriving while rst=0 is ignored.

Decomposition:
- Shared package arm_pkg: NOP_INSTR, WORD_BYTES=4, FSM state enum {FETCH, HELD, DISCARD}.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/flush/hold priority flush > hold > load.
- FSM, PC and skid buffer stay in if_stage.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: RESET_PC=0, zero-wait memory (ack every cycle after req), rdata=addr.
  - Response: instruction=0,4,8 on consecutive cycles; PC=4,8,12; valid=1.
- Freeze with skid:
  - Stimulus: freeze=1 on the cycle ack returns addr 8.
  - Response: IF/ID holds addr 4; imem_req=0.
  - Stimulus: freeze drops after 3 cycles.
  - Response: instruction=8, PC=12 next cycle; then the fetch of 12 issues.
- Branch during wait:
  - Stimulus: 3-cycle memory latency; branch_taken, branch_address=0x100 one cycle after req for 0x10.
  - Response: valid=0 with NOP_INSTR next cycle; 0x10 data discarded; next imem_addr=0x100; then instruction=0x100, PC=0x104.
- Branch+freeze+ack same cycle:
  - Stimulus: all three asserted, target 0x40.
  - Response: bubble; skid empty; next request 0x40.
- Wrap-around:
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Response: PC output 0; next imem_addr=0.
- Async reset mid-request:
  - Stimulus: rst=0 while waiting for ack.
  - Response: imem_req=0 and valid=0 immediately, no clock needed; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared constants and types for the ARM-style fetch front end.
package arm_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        StFetch,
        StHeld,
        StDiscard
    } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; priority flush > hold > load.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = arm_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!hold_i && load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem port, one-entry skid
// buffer and the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = arm_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);

    import arm_pkg::*;

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] pc_plus4, target;
    logic        id_load;
    logic [31:0] id_pc, id_instr;

    assign pc_plus4  = pc_q + WORD_BYTES;
    assign target    = branch_address & ~32'h3;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            skid_q    <= NOP_INSTR;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            skid_q    <= skid_d;
        end
    end

    // pc_q only moves on an ack or an idle redirect, keeping imem_addr stable
    // for the in-flight request; a redirect during a wait parks in next_pc_q.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        skid_d    = skid_q;
        unique case (state_q)
            StFetch: begin
                if (branch_taken) begin
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        next_pc_d = target;
                        state_d   = StDiscard;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (freeze) begin
                        skid_d  = imem_rdata;
                        state_d = StHeld;
                    end
                end
            end
            StHeld: begin
                if (branch_taken) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (!freeze) begin
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                if (imem_ack) begin
                    pc_d    = branch_taken ? target : next_pc_q;
                    state_d = StFetch;
                end else if (branch_taken) begin
                    next_pc_d = target;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // In StHeld pc_q already points past the skid word, so it is the IF/ID PC.
    always_comb begin
        imem_req = 1'b0;
        id_load  = 1'b0;
        id_pc    = pc_plus4;
        id_instr = imem_rdata;
        unique case (state_q)
            StFetch: begin
                imem_req = rst;
                id_load  = imem_ack;
            end
            StHeld: begin
                id_load  = 1'b1;
                id_pc    = pc_q;
                id_instr = skid_q;
            end
            default: imem_req = rst;
        endcase
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (branch_taken),
        .hold_i  (freeze),
        .load_i  (id_load),
        .pc_i    (id_pc),
        .instr_i (id_instr),
        .pc_o    (PC),
        .instr_o (instruction),
        .valid_o (valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage, plus a second instance checking PC wrap-around.
module tb_if_stage;

    localparam logic [31:0] Nop = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] pc_o, instr_o;
    logic        valid_o;

    logic        w_req, w_ack = 1'b0;
    logic [31:0] w_addr, w_rdata = '0;
    logic [31:0] w_pc, w_instr;
    logic        w_valid;
    logic        w_freeze = 1'b0, w_branch = 1'b0;
    logic [31:0] w_baddr = '0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PC             (pc_o),
        .instruction    (instr_o),
        .valid          (valid_o)
    );

    if_stage #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .freeze         (w_freeze),
        .branch_taken   (w_branch),
        .branch_address (w_baddr),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .PC             (w_pc),
        .instruction    (w_instr),
        .valid          (w_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_is(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic v);
        check_eq({tag, "_instr"}, instr_o, ins);
        check_eq({tag, "_pc"}, pc_o, pc);
        check_eq({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    endtask

    initial begin
        #12;
        id_is("reset", Nop, 32'h0, 1'b0);
        check_eq("reset_req", {31'd0, imem_req}, 32'd0);
        check_eq("reset_wreq", {31'd0, w_req}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("first_req", {31'd0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        check_eq("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

        // Sequential zero-wait fetch, rdata = address
        imem_ack = 1'b1; imem_rdata = 32'h0;
        w_ack = 1'b1; w_rdata = 32'h1234_5678;
        step();
        id_is("seq0", 32'h0, 32'h4, 1'b1);
        check_eq("seq0_addr", imem_addr, 32'h4);
        check_eq("wrap_pc", w_pc, 32'h0);
        check_eq("wrap_instr", w_instr, 32'h1234_5678);
        check_eq("wrap_next_addr", w_addr, 32'h0);
        w_ack = 1'b0;
        imem_rdata = 32'h4;
        step();
        id_is("seq1", 32'h4, 32'h8, 1'b1);
        check_eq("seq1_addr", imem_addr, 32'h8);

        // Freeze on the ack of 8: word goes to skid, IF/ID holds
        imem_rdata = 32'h8; freeze = 1'b1;
        step();
        id_is("frz0", 32'h4, 32'h8, 1'b1);
        check_eq("frz0_req", {31'd0, imem_req}, 32'd0);
        check_eq("frz0_addr", imem_addr, 32'hC);
        imem_ack = 1'b0;
        step();
        step();
        id_is("frz2", 32'h4, 32'h8, 1'b1);
        check_eq("frz2_req", {31'd0, imem_req}, 32'd0);
        freeze = 1'b0;
        step();
        id_is("unfrz", 32'h8, 32'hC, 1'b1);
        check_eq("unfrz_req", {31'd0, imem_req}, 32'd1);
        check_eq("unfrz_addr", imem_addr, 32'hC);
        imem_ack = 1'b1; imem_rdata = 32'hC;
        step();
        id_is("seq12", 32'hC, 32'h10, 1'b1);

        // Branch while waiting on 0x10 (3-cycle latency)
        imem_ack = 1'b0;
        step();
        branch_taken = 1'b1; branch_address = 32'h100;
        step();
        id_is("br_wait", Nop, 32'h0, 1'b0);
        check_eq("br_wait_addr", imem_addr, 32'h10);
        check_eq("br_wait_req", {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b0;
        step();
        check_eq("disc_addr", imem_addr, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'h10;
        step();
        check_eq("disc_done_addr", imem_addr, 32'h100);
        check_eq("disc_dropped", {31'd0, valid_o}, 32'd0);
        imem_rdata = 32'h100;
        step();
        id_is("tgt", 32'h100, 32'h104, 1'b1);

        // Branch + freeze + ack in the same cycle
        imem_rdata = 32'h104; freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h40;
        step();
        id_is("bfa", Nop, 32'h0, 1'b0);
        check_eq("bfa_addr", imem_addr, 32'h40);
        imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        step();
        check_eq("bfa_skid_empty", {31'd0, imem_req}, 32'd1);
        check_eq("bfa_still_bubble", {31'd0, valid_o}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h40;
        step();
        id_is("bfa_tgt", 32'h40, 32'h44, 1'b1);

        // Second branch during discard overwrites the target; low bits ignored
        imem_ack = 1'b0; branch_taken = 1'b1; branch_address = 32'h200;
        step();
        check_eq("dd_addr0", imem_addr, 32'h44);
        branch_address = 32'h302;
        step();
        check_eq("dd_addr1", imem_addr, 32'h44);
        branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h44;
        step();
        check_eq("dd_target", imem_addr, 32'h300);

        // Branch while held clears the skid
        imem_rdata = 32'h300; freeze = 1'b1;
        step();
        check_eq("held_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0; branch_taken = 1'b1; branch_address = 32'h80;
        step();
        check_eq("held_br_addr", imem_addr, 32'h80);
        check_eq("held_br_req", {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b0; freeze = 1'b0;
        step();
        check_eq("held_skid_dropped", {31'd0, valid_o}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h80;
        step();
        id_is("held_tgt", 32'h80, 32'h84, 1'b1);

        // Asynchronous reset while a request is pending
        imem_ack = 1'b0;
        step();
        #3 rst = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, imem_req}, 32'd0);
        id_is("arst", Nop, 32'h0, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        check_eq("arst_ack_ignored", {31'd0, valid_o}, 32'd0);
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_restart_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0;
        step();
        id_is("restart", 32'h0, 32'h4, 1'b1);
        imem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
